// File: rtl/sram_c_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sram_c_reader_pkg
//  Purpose  : Shared widths, defaults and FSM encoding for the SRAM_C reader.
//  Revision : 1.0 - initial release
// ============================================================================
package sram_c_reader_pkg;

    localparam int c_ADDR_W     = 12;
    localparam int c_DATA_W     = 22;
    localparam int c_RD_LAT     = 1;
    localparam int c_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    function automatic logic is_active(input state_t s);
        return (s == READ) || (s == DRAIN);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_c_reader_if.sv
`default_nettype none
// ============================================================================
//  Module   : sram_c_reader_if
//  Purpose  : SRAM_C read port plus the valid/ready result stream.
//  Revision : 1.0 - initial release
// ============================================================================
interface sram_c_reader_if
    import sram_c_reader_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W
);
    logic              NCE_C;
    logic              nwrt_C;
    logic [ADDR_W-1:0] address_C;
    logic [DATA_W-1:0] Out_C;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;

    modport master (
        output NCE_C, nwrt_C, address_C, m_data, m_valid,
        input  Out_C, m_ready
    );

    modport slave (
        input  NCE_C, nwrt_C, address_C, m_data, m_valid,
        output Out_C, m_ready
    );
endinterface
`default_nettype wire

// File: rtl/sram_c_reader_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sram_c_reader_sync_fifo
//  Purpose  : Power-of-two synchronous FIFO, registered head, no bypass.
//  Revision : 1.0 - initial release
// ============================================================================
module sram_c_reader_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 22
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign count = r_wr_ptr - r_rd_ptr;
    assign dout  = r_mem[r_rd_ptr[c_AW-1:0]];

    assign w_do_pop  = pop & ~empty;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[c_AW-1:0]] <= din;
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/sram_c_reader.sv
`default_nettype none
// ============================================================================
//  Module   : sram_c_reader
//  Purpose  : Streams every SRAM_C word in address order over valid/ready,
//             hiding read latency with a credit-limited output FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
module sram_c_reader
    import sram_c_reader_pkg::*;
#(
    parameter int ADDR_W     = c_ADDR_W,
    parameter int DATA_W     = c_DATA_W,
    parameter int RD_LAT     = c_RD_LAT,
    parameter int FIFO_DEPTH = c_FIFO_DEPTH
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           busy,
    output logic           done,
    sram_c_reader_if.master bus
);
    localparam int                c_CW    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_CW-1:0]   c_DEPTH = c_CW'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] c_LAST  = '1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_issue_addr;
    logic              r_nce;
    logic              w_issue;
    logic [c_CW-1:0]   r_credit;
    logic [c_CW-1:0]   w_credit_nxt;
    logic [RD_LAT-1:0] r_lat_sr;
    logic              r_busy;
    logic              r_done;
    logic              w_pop;
    logic              w_empty;
    logic              w_full;
    logic [c_CW-1:0]   w_count;
    logic [DATA_W-1:0] w_dout;
    logic              w_unused;

    assign w_pop = ~w_empty & bus.m_ready;

    // Credit for the cycle in which the next read would be presented:
    // the read currently on the bus is counted, the current pop released.
    assign w_credit_nxt = r_credit + {{(c_CW-1){1'b0}}, ~r_nce}
                                   - {{(c_CW-1){1'b0}}, w_pop};

    always_comb begin
        w_state_nxt  = r_state;
        w_issue      = 1'b0;
        w_issue_addr = r_rd_ptr;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_issue      = 1'b1;
                    w_issue_addr = '0;
                    w_state_nxt  = READ;
                end
            end
            READ: begin
                if (w_credit_nxt < c_DEPTH) begin
                    w_issue = 1'b1;
                    if (r_rd_ptr == c_LAST) begin
                        w_state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (w_credit_nxt == '0) begin
                    w_state_nxt = FIN;
                end
            end
            FIN:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_rd_ptr <= '0;
            r_addr   <= '0;
            r_nce    <= 1'b1;
            r_credit <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_nce    <= ~w_issue;
            r_credit <= w_credit_nxt;
            r_busy   <= is_active(w_state_nxt);
            r_done   <= (w_state_nxt == FIN);
            if (w_issue) begin
                r_addr <= w_issue_addr;
                // Pointer saturates on the last address; a new start reloads it.
                if (w_issue_addr != c_LAST) begin
                    r_rd_ptr <= w_issue_addr + 1'b1;
                end
            end
        end
    end

    if (RD_LAT == 1) begin : g_lat_one
        always_ff @(posedge clk) begin
            if (rst) r_lat_sr <= '0;
            else     r_lat_sr <= ~r_nce;
        end
    end else begin : g_lat_multi
        always_ff @(posedge clk) begin
            if (rst) r_lat_sr <= '0;
            else     r_lat_sr <= {r_lat_sr[RD_LAT-2:0], ~r_nce};
        end
    end

    sram_c_reader_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (r_lat_sr[RD_LAT-1]),
        .pop   (w_pop),
        .din   (bus.Out_C),
        .dout  (w_dout),
        .empty (w_empty),
        .full  (w_full),
        .count (w_count)
    );

    assign w_unused      = ^{w_full, w_count};
    assign bus.NCE_C     = r_nce;
    assign bus.nwrt_C    = 1'b1;
    assign bus.address_C = r_addr;
    assign bus.m_data    = w_dout;
    assign bus.m_valid   = ~w_empty;
    assign busy          = r_busy;
    assign done          = r_done;
endmodule
`default_nettype wire

// File: tb/tb_sram_c_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_c_reader
//  Purpose  : Directed self-checking bench for sram_c_reader (RD_LAT 1 and 2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sram_c_reader;
    logic clk;
    logic rst;
    logic start;
    logic start2;
    logic busy, done, busy2, done2;

    int checks = 0;
    int errors = 0;

    logic [21:0] mem [4096];
    logic [21:0] p2;

    sram_c_reader_if #(.ADDR_W(12), .DATA_W(22)) bus  ();
    sram_c_reader_if #(.ADDR_W(12), .DATA_W(22)) bus2 ();

    sram_c_reader #(.ADDR_W(12), .DATA_W(22), .RD_LAT(1), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .bus(bus));

    sram_c_reader #(.ADDR_W(12), .DATA_W(22), .RD_LAT(2), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!bus.NCE_C) bus.Out_C <= mem[bus.address_C];
    end

    always @(posedge clk) begin
        if (!bus2.NCE_C) p2 <= mem[bus2.address_C];
        bus2.Out_C <= p2;
    end

    int words, word_bad, done_cnt, done_cyc, issued, addr_bad, nce_full;
    int unstable, nwrt_bad, credit_m, first_valid_cyc, busy_c1;
    int issued_at_low, nce_at_low, words2, word2_bad, done2_cyc, late_done;
    logic        prev_hold;
    logic [21:0] prev_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_xfer(input int ready_pct, input int low_cycles, input int restart1,
                            input int restart2, input int rst_word, input bit use2,
                            input int max_cyc);
        int c;
        bit r1, r2, fin;
        int hs;
        words = 0; word_bad = 0; done_cnt = 0; done_cyc = -1; issued = 0; addr_bad = 0;
        nce_full = 0; unstable = 0; nwrt_bad = 0; credit_m = 0; first_valid_cyc = -1;
        busy_c1 = 0; issued_at_low = -1; nce_at_low = -1; words2 = 0; word2_bad = 0;
        done2_cyc = -1; prev_hold = 1'b0; prev_data = '0;
        c = 0; r1 = 0; r2 = 0; fin = 0;
        while (!fin) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            if (rst_word >= 0 && words == rst_word) begin
                rst = 1'b1;
                start = 1'b0;
                bus.m_ready = 1'b0;
                return;
            end
            start  = (c == 0);
            start2 = use2 && (c == 0);
            if (!r1 && restart1 >= 0 && c > 0 && words == restart1) begin
                start = 1'b1;
                r1 = 1;
            end else if (!r2 && restart2 >= 0 && c > 0 && words == restart2) begin
                start = 1'b1;
                r2 = 1;
            end
            if (c < low_cycles)       bus.m_ready = 1'b0;
            else if (ready_pct >= 100) bus.m_ready = 1'b1;
            else                       bus.m_ready = ($urandom_range(99) < ready_pct);

            if (bus.nwrt_C !== 1'b1) nwrt_bad++;
            if (!bus.NCE_C) begin
                if (credit_m >= 4) nce_full++;
                if (bus.address_C !== 12'(issued)) addr_bad++;
                issued++;
            end
            if (prev_hold && (!bus.m_valid || bus.m_data !== prev_data)) unstable++;
            prev_hold = bus.m_valid && !bus.m_ready;
            prev_data = bus.m_data;
            if (bus.m_valid && first_valid_cyc < 0) first_valid_cyc = c;
            hs = (bus.m_valid && bus.m_ready) ? 1 : 0;
            if (hs == 1) begin
                if (words >= 4096 || bus.m_data !== mem[words]) word_bad++;
                words++;
            end
            credit_m = credit_m + (bus.NCE_C ? 0 : 1) - hs;
            if (c == 1) busy_c1 = int'(busy);
            if (c == low_cycles - 1) begin
                issued_at_low = issued;
                nce_at_low    = int'(bus.NCE_C);
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (use2) begin
                if (bus2.m_valid) begin
                    if (words2 >= 4096 || bus2.m_data !== mem[words2]) word2_bad++;
                    words2++;
                end
                if (done2 && done2_cyc < 0) done2_cyc = c;
            end
            c++;
            if (c >= max_cyc) fin = 1;
            if (done_cyc >= 0 && c > done_cyc + 5 && (!use2 || done2_cyc >= 0)) fin = 1;
        end
        start  = 1'b0;
        start2 = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start2 = 1'b0;
        bus.m_ready = 1'b0; bus2.m_ready = 1'b1;
        for (int i = 0; i < 4096; i++) mem[i] = 22'(i * 3);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_nce",    64'(bus.NCE_C),     64'd1);
        chk("rst_nwrt",   64'(bus.nwrt_C),    64'd1);
        chk("rst_addr",   64'(bus.address_C), 64'd0);
        chk("rst_valid",  64'(bus.m_valid),   64'd0);
        chk("rst_data",   64'(bus.m_data),    64'd0);
        chk("rst_busy",   64'(busy),          64'd0);
        chk("rst_done",   64'(done),          64'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Full-rate stream on both latency builds
        run_xfer(100, 0, -1, -1, -1, 1'b1, 6000);
        chk("t1_words",     64'(words),           64'd4096);
        chk("t1_word_bad",  64'(word_bad),        64'd0);
        chk("t1_done_cnt",  64'(done_cnt),        64'd1);
        chk("t1_done_cyc",  64'(done_cyc),        64'd4099);
        chk("t1_issued",    64'(issued),          64'd4096);
        chk("t1_addr_bad",  64'(addr_bad),        64'd0);
        chk("t1_nwrt_bad",  64'(nwrt_bad),        64'd0);
        chk("t1_busy_c1",   64'(busy_c1),         64'd1);
        chk("t1_first_vld", 64'(first_valid_cyc), 64'd3);
        chk("t6_words",     64'(words2),          64'd4096);
        chk("t6_word_bad",  64'(word2_bad),       64'd0);
        chk("t6_done_cyc",  64'(done2_cyc),       64'd4100);

        // Random 30% back-pressure with descending data
        for (int i = 0; i < 4096; i++) mem[i] = 22'h3FFFFF - 22'(i);
        run_xfer(30, 0, -1, -1, -1, 1'b0, 25000);
        chk("t2_words",     64'(words),    64'd4096);
        chk("t2_word_bad",  64'(word_bad), 64'd0);
        chk("t2_done_cnt",  64'(done_cnt), 64'd1);
        chk("t2_addr_bad",  64'(addr_bad), 64'd0);
        chk("t2_nce_full",  64'(nce_full), 64'd0);
        chk("t2_unstable",  64'(unstable), 64'd0);

        // Sink stalled for the first 20 cycles
        run_xfer(100, 20, -1, -1, -1, 1'b0, 6000);
        chk("t3_issued_low", 64'(issued_at_low), 64'd4);
        chk("t3_nce_low",    64'(nce_at_low),    64'd1);
        chk("t3_words",      64'(words),         64'd4096);
        chk("t3_word_bad",   64'(word_bad),      64'd0);
        chk("t3_addr_bad",   64'(addr_bad),      64'd0);
        chk("t3_nce_full",   64'(nce_full),      64'd0);

        // Extra start pulses mid-stream and at the last word
        run_xfer(100, 0, 100, 4095, -1, 1'b0, 6000);
        chk("t4_words",     64'(words),    64'd4096);
        chk("t4_word_bad",  64'(word_bad), 64'd0);
        chk("t4_done_cnt",  64'(done_cnt), 64'd1);
        chk("t4_done_cyc",  64'(done_cyc), 64'd4099);
        chk("t4_issued",    64'(issued),   64'd4096);

        // Reset mid-transfer, then a clean restart
        run_xfer(100, 0, -1, -1, 2000, 1'b0, 6000);
        chk("t5_rst_words", 64'(words), 64'd2000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t5_valid_after_rst", 64'(bus.m_valid), 64'd0);
        chk("t5_busy_after_rst",  64'(busy),        64'd0);
        chk("t5_nce_after_rst",   64'(bus.NCE_C),   64'd1);
        late_done = 0;
        for (int i = 0; i < 10; i++) begin
            if (done || bus.m_valid) late_done++;
            @(posedge clk);
            #1;
        end
        chk("t5_quiet_after_rst", 64'(late_done), 64'd0);
        run_xfer(100, 0, -1, -1, -1, 1'b0, 6000);
        chk("t5_words",     64'(words),           64'd4096);
        chk("t5_word_bad",  64'(word_bad),        64'd0);
        chk("t5_first_vld", 64'(first_valid_cyc), 64'd3);
        chk("t5_done_cyc",  64'(done_cyc),        64'd4099);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
